conv_fmap_reader: RTL and testbench
===================================

Name: conv_fmap_reader

Overview:
- Consumer at the far end of the multi-filter convolution layer's flat output bus.
- On the rising edge of the layer's done flag, snapshots the whole K x L feature map (K filters, L outputs each, 16-bit sign-magnitude words).
- Streams the map out one word per cycle over a valid/ready handshake, tagged with channel, index and last.
- Optional ReLU on the way out; feeds the pooling/dense stage.

Parameters:
- DATA_WIDTH, 16, word width, sign-magnitude (MSB = sign).
- K, 4, number of filter channels.
- L, 128, outputs per channel; equals ((W+2P-F)/S)+1 = ((1024+56-64)/8)+1.
- RELU_EN, 1, 1 = negative words (sign bit set) are output as zero.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- done_flag, input, 1, level "feature map valid" from the conv layer.
- feature_in, input, [0:K*L*DATA_WIDTH-1], flat map; word n = feature_in[n*DATA_WIDTH +: DATA_WIDTH]; channel-major, n = c*L + i.
- m_data, output, [DATA_WIDTH-1:0], streamed word.
- m_valid, output, 1, m_data/m_chan/m_idx/m_last valid.
- m_ready, input, 1, downstream accepts.
- m_chan, output, $clog2(K), channel of the current word.
- m_idx, output, $clog2(L), position within the channel.
- m_last, output, 1, high with the final word (c=K-1, i=L-1).
- busy, output, 1, high from capture until the last handshake.
- frame_done, output, 1, one-cycle pulse after the last handshake.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; state IDLE; word counter 0.
  - done_prev register = 1, so a done_flag already high at reset release is not treated as an edge. A new frame requires done_flag to go low, then high.
- Rise detection: rise = done_flag & ~done_prev; done_prev <= done_flag every cycle.
- State IDLE:
  - On rise at cycle t, copy feature_in into the internal buffer (K*L*DATA_WIDTH bits).
  - Set busy=1 and load output registers with word 0 (c=0, i=0).
  - m_valid=1 from cycle t+1. Go to STREAM.
- State STREAM:
  - Handshake = m_valid & m_ready.
  - On a handshake of word n < K*L-1, output registers load word n+1 in the next cycle with no bubble, so sustained throughput is 1 word/cycle.
  - Without a handshake, m_data, m_chan, m_idx and m_last hold stable.
  - m_idx wraps L-1 -> 0 while m_chan increments.
  - m_last = 1 exactly when n = K*L-1.
  - On the handshake of the last word: m_valid=0, busy=0 and frame_done=1 for one cycle, then IDLE.
- ReLU: if RELU_EN and word[DATA_WIDTH-1]=1, m_data = 0 (this includes -0, 0x8000). Otherwise the word passes unchanged.
- The buffer is isolated from feature_in after capture: changes to feature_in or done_flag during STREAM are ignored. A rise during STREAM is dropped; no queuing.
- m_ready may be high before m_valid; no handshake occurs while m_valid=0.
- Reset mid-STREAM aborts the frame immediately, with no frame_done.
- Total time for a frame with m_ready held at 1: capture at t, words at t+1 .. t+K*L, frame_done at t+K*L+1.

Decomposition:
- Shared package conv_pkg:
  - DATA_WIDTH, K, L and the W/P/F/S constants from which L is derived.
  - Typedef for a sign-magnitude word.
  - Function sm_relu(word).
- One natural sub-module: rise_detect (flop plus AND, reset value 1), reused wherever done flags cross stages.
- FSM, counters and buffer stay inline.

Test Plan:
1. Pattern word n = n, m_ready=1, rise at cycle 10 -> m_valid from cycle 11; 512 consecutive words 0..511; m_chan/m_idx = (n/128, n%128); m_last only on word 511; frame_done at cycle 523.
2. RELU_EN=1, words 0x8005, 0x8000, 0x0007, 0x7FFF -> outputs 0x0000, 0x0000, 0x0007, 0x7FFF. With RELU_EN=0 -> the words unchanged.
3. Random m_ready (50% duty) -> no word dropped or duplicated, m_data stable whenever m_valid & !m_ready, 512 handshakes total.
4. Change feature_in to all 0xFFFF and toggle done_flag mid-STREAM -> stream continues with the captured values; no second frame starts.
5. done_flag held high through reset release -> no frame until done_flag goes low then high; then exactly one frame.
6. Assert reset at word 200 -> all outputs 0 within the same cycle; no frame_done. A fresh rise restarts from word 0, c=0, i=0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, sign-magnitude word type and ReLU helper for the
// convolution layer and its consumers.
package conv_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int K          = 4;
  // Input length, padding, filter size and stride of the conv layer
  localparam int W          = 1024;
  localparam int P          = 28;
  localparam int F          = 64;
  localparam int S          = 8;
  localparam int L          = ((W + 2 * P - F) / S) + 1;

  typedef logic [DATA_WIDTH-1:0] sm_word_t;

  // Any word with the sign bit set, including -0, becomes +0.
  function automatic sm_word_t sm_relu(input sm_word_t w);
    return w[DATA_WIDTH-1] ? '0 : w;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for level done flags. The history flop resets high,
// so a flag that is already high when reset is released is not an edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_prev <= 1'b1;
    else        d_prev <= d;
  end

  assign rise = d & ~d_prev;

endmodule

// File: rtl/conv_fmap_reader.sv
// Snapshots the K x L conv feature map on done_flag rising and streams it
// one word per cycle, tagged with channel/index/last, with optional ReLU.
module conv_fmap_reader
  import conv_pkg::*;
#(
  parameter  int K       = conv_pkg::K,
  parameter  int L       = conv_pkg::L,
  parameter  int RELU_EN = 1,
  localparam int CW      = (K > 1) ? $clog2(K) : 1,
  localparam int IW      = (L > 1) ? $clog2(L) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          done_flag,
  input  logic [0:K*L*DATA_WIDTH-1]     feature_in,
  output sm_word_t                      m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CW-1:0]                 m_chan,
  output logic [IW-1:0]                 m_idx,
  output logic                          m_last,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          dbg_state
);

  // Output stream: m_data/m_chan/m_idx/m_last are valid while m_valid is high
  // and hold stable until the cycle m_valid & m_ready is sampled high.
  localparam int N  = K * L;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(N * DATA_WIDTH);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  localparam logic [NW-1:0] LAST_N  = NW'(N - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(L - 1);

  logic [0:0]              state_q;
  logic [NW-1:0]           n_q;
  logic [NW-1:0]           next_n;
  logic [BW-1:0]           next_base;
  logic [0:N*DATA_WIDTH-1] buf_q;
  sm_word_t                next_word;
  logic                    rise;
  logic                    hs;

  function automatic sm_word_t relu_opt(input sm_word_t w);
    return (RELU_EN != 0) ? sm_relu(w) : w;
  endfunction

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .d     (done_flag),
    .rise  (rise)
  );

  assign hs        = m_valid & m_ready;
  assign dbg_state = state_q;

  always_comb begin
    next_n    = n_q + 1'b1;
    next_base = BW'(next_n) * BW'(DATA_WIDTH);
    next_word = buf_q[next_base +: DATA_WIDTH];
  end

  // Snapshot only; the stream never reads feature_in after this.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && rise) buf_q <= feature_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_chan     <= '0;
      m_idx      <= '0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_q <= S_STREAM;
            n_q     <= '0;
            m_data  <= relu_opt(feature_in[0 +: DATA_WIDTH]);
            m_chan  <= '0;
            m_idx   <= '0;
            m_last  <= (N == 1);
            m_valid <= 1'b1;
            busy    <= 1'b1;
          end
        end
        default: begin
          if (hs) begin
            if (m_last) begin
              state_q    <= S_IDLE;
              m_valid    <= 1'b0;
              m_last     <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              n_q    <= next_n;
              m_data <= relu_opt(next_word);
              m_last <= (next_n == LAST_N);
              if (m_idx == IDX_MAX) begin
                m_idx  <= '0;
                m_chan <= m_chan + 1'b1;
              end else begin
                m_idx  <= m_idx + 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_fmap_reader.sv
// Bench for conv_fmap_reader: one ReLU instance under test with variable
// m_ready, one pass-through instance always ready, both scoreboarded.
module tb_conv_fmap_reader;
  import conv_pkg::*;

  localparam int NW = K * L;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              done_flag = 1'b1;
  logic              m_ready = 1'b1;
  logic [0:NW*16-1]  feature_in = '0;

  sm_word_t    m_data, b_data;
  logic        m_valid, m_last, busy, frame_done, dbg_state;
  logic        b_valid, b_last, b_busy, b_frame_done, b_dbg_state;
  logic [1:0]  m_chan, b_chan;
  logic [6:0]  m_idx, b_idx;

  conv_fmap_reader #(.K(K), .L(L), .RELU_EN(1)) dut (
    .clk(clk), .reset(reset), .done_flag(done_flag), .feature_in(feature_in),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_chan(m_chan),
    .m_idx(m_idx), .m_last(m_last), .busy(busy), .frame_done(frame_done),
    .dbg_state(dbg_state)
  );

  conv_fmap_reader #(.K(K), .L(L), .RELU_EN(0)) dut_raw (
    .clk(clk), .reset(reset), .done_flag(done_flag), .feature_in(feature_in),
    .m_data(b_data), .m_valid(b_valid), .m_ready(1'b1), .m_chan(b_chan),
    .m_idx(b_idx), .m_last(b_last), .busy(b_busy), .frame_done(b_frame_done),
    .dbg_state(b_dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  logic [15:0] mem [NW];
  logic [31:0] exp_q[$];
  logic [31:0] raw_q[$];
  int fd_count = 0, fd_b_count = 0, exp_frames = 0, hs_count = 0;
  int fv_cyc = 0, fd_cyc = 0, drive_cyc = 0;
  logic prev_hold = 1'b0, prev_valid = 1'b0;
  logic [31:0] prev_obs = '0;

  function automatic logic [31:0] pack(input int n, input logic [15:0] d);
    return {6'b0, (n == NW - 1), 2'(n / L), 7'(n % L), d};
  endfunction

  // Scoreboard for the ReLU instance, including hold-while-stalled check
  always @(negedge clk) begin
    logic [31:0] obs;
    obs = {6'b0, m_last, m_chan, m_idx, m_data};
    if (prev_hold) check("hold", {m_valid, obs[30:0]}, {1'b1, prev_obs[30:0]});
    if (m_valid && !prev_valid) fv_cyc = cyc;
    if (m_valid && m_ready) begin
      hs_count++;
      if (exp_q.size() == 0) check("extra_word", obs, 32'hDEAD_BEEF);
      else check("word", obs, exp_q.pop_front());
    end
    if (frame_done) begin
      fd_count++;
      fd_cyc = cyc;
      check("busy_at_done", {31'b0, busy}, 32'd0);
    end
    prev_hold  = m_valid && !m_ready;
    prev_obs   = obs;
    prev_valid = m_valid;
  end

  // Scoreboard for the pass-through instance
  always @(negedge clk) begin
    if (b_valid) begin
      if (raw_q.size() == 0) check("extra_raw", {6'b0, b_last, b_chan, b_idx, b_data}, 32'hDEAD_BEEF);
      else check("raw_word", {6'b0, b_last, b_chan, b_idx, b_data}, raw_q.pop_front());
    end
    if (b_frame_done) fd_b_count++;
  end

  task automatic set_features();
    for (int n = 0; n < NW; n++) feature_in[n*16 +: 16] = mem[n];
  endtask

  task automatic start_frame();
    @(posedge clk); #1 done_flag = 1'b0;
    @(posedge clk); #1 done_flag = 1'b1;
    drive_cyc = cyc;
    hs_count  = 0;
    exp_frames++;
    for (int n = 0; n < NW; n++) begin
      exp_q.push_back(pack(n, mem[n][15] ? 16'h0000 : mem[n]));
      raw_q.push_back(pack(n, mem[n]));
    end
  endtask

  task automatic wait_frame(input string tag);
    for (int i = 0; i < 5000 && fd_count < exp_frames; i++) @(negedge clk);
    @(negedge clk);
    check({tag, "_frames"}, 32'(fd_count), 32'(exp_frames));
    check({tag, "_raw_frames"}, 32'(fd_b_count), 32'(exp_frames));
    check({tag, "_handshakes"}, 32'(hs_count), 32'(NW));
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_raw_q_empty"}, 32'(raw_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] all_outs();
    return {14'b0, m_valid, busy, frame_done, m_last, dbg_state, m_chan, m_idx, m_data[3:0],
            b_valid, b_busy, b_frame_done, b_last, b_dbg_state, |b_data, |m_data};
  endfunction

  initial begin
    // Reset with done_flag held high through release
    repeat (3) @(posedge clk);
    #1 check("reset_state", all_outs(), 32'd0);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("no_frame_held_flag", {30'b0, m_valid, busy}, 32'd0);
    check("no_done_held_flag", 32'(fd_count + fd_b_count), 32'd0);

    // Ramp pattern with m_ready always high, timing checks
    for (int n = 0; n < NW; n++) mem[n] = 16'(n);
    set_features();
    start_frame();
    wait_frame("ramp");
    check("first_valid_cyc", 32'(fv_cyc), 32'(drive_cyc + 1));
    check("frame_done_cyc", 32'(fd_cyc), 32'(drive_cyc + 1 + NW));

    // ReLU corner words plus random fill
    for (int n = 0; n < NW; n++) mem[n] = 16'($urandom_range(0, 65535));
    mem[0] = 16'h8005; mem[1] = 16'h8000; mem[2] = 16'h0007; mem[3] = 16'h7FFF;
    mem[NW-1] = 16'h8000;
    set_features();
    start_frame();
    wait_frame("relu");

    // Random backpressure
    for (int n = 0; n < NW; n++) mem[n] = 16'($urandom_range(0, 65535));
    set_features();
    start_frame();
    for (int i = 0; i < 4000 && fd_count < exp_frames; i++) begin
      @(posedge clk); #1 m_ready = 1'($urandom_range(0, 1));
    end
    m_ready = 1'b1;
    wait_frame("backpressure");

    // Input changes and done_flag toggles mid-stream are ignored
    for (int n = 0; n < NW; n++) mem[n] = 16'(3 * n + 1);
    set_features();
    start_frame();
    repeat (100) @(posedge clk);
    #1 feature_in = '1; done_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1 done_flag = 1'b1;
    repeat (2) @(posedge clk);
    #1 done_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1 done_flag = 1'b1;
    wait_frame("isolate");
    repeat (30) @(negedge clk);
    check("no_second_frame", {30'b0, m_valid, busy}, 32'd0);
    check("no_second_done", 32'(fd_count), 32'(exp_frames));

    // Reset at word 200 aborts, then a fresh rise restarts from word 0
    for (int n = 0; n < NW; n++) mem[n] = 16'(n ^ 16'h0A5A);
    set_features();
    start_frame();
    for (int i = 0; i < 1000 && hs_count < 200; i++) @(negedge clk);
    check("reached_word_200", 32'(hs_count), 32'd200);
    @(posedge clk); #1 reset = 1'b0;
    #1 check("abort_outputs", all_outs(), 32'd0);
    exp_q.delete();
    raw_q.delete();
    exp_frames--;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_abort", 32'(fd_count), 32'(exp_frames));
    check("idle_after_abort", {30'b0, m_valid, busy}, 32'd0);
    fd_b_count = fd_count;
    start_frame();
    wait_frame("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
